stage_ex: RTL
=============

// Module: stage_ex
// PURPOSE
//  Execute stage of the 5-stage 16-bit TSC pipeline, directly upstream of the MEM stage.
//  Resolves operands through a forwarding mux and runs the ALU.
//  Resolves branches and jumps, and owns the EX/MEM pipeline latch that drives MEM's instruction/addr/write_data.
//  Freezes on MEM's memoryWait; squashes the wrong-path instruction after a redirect.
// PARAMETERS
//  WORD_SIZE  16  datapath and instruction width
//  LINK_REG   2   register written by JAL/JRL
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   synchronous, active-low reset
//  in_valid       in   1   ID/EX holds a real instruction
//  in_inst        in   16  instruction from ID
//  in_pc          in   16  PC of in_inst
//  in_rs_data     in   16  register-file value of rs
//  in_rt_data     in   16  register-file value of rt
//  mem_wait       in   1   memoryWait from MEM; stalls the whole pipe
//  mem_fwd_en     in   1   MEM instr writes a register and its result is valid
//  mem_fwd_reg    in   2   MEM destination register
//  mem_fwd_data   in   16  MEM result (ALU value or load data)
//  wb_fwd_en      in   1   WB instr writes a register
//  wb_fwd_reg     in   2   WB destination register
//  wb_fwd_data    in   16  WB value
//  ex_ready       out  1   ~mem_wait; ID may advance
//  out_valid      out  1   EX/MEM latch valid
//  out_inst       out  16  latched instruction (MEM decodes LWD/SWD from it)
//  out_addr       out  16  ALU result / memory address
//  out_write_data out  16  forwarded rt (SWD store data)
//  out_dest       out  2   destination register
//  out_reg_write  out  1   latched instr writes a register
//  redirect_valid out  1   one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc    out  16  branch/jump target
//  wwd_value      out  16  last WWD operand
//  halted         out  1   sticky; HLT reached EX/MEM
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    - out_valid=0, out_inst=16'h0, out_addr=0, out_write_data=0, out_dest=0, out_reg_write=0.
//    - redirect_valid=0, redirect_pc=0, wwd_value=0, halted=0.
//  - Decode fields: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0], imm[7:0] (sign-extended; zero-extended for ORI), target[11:0].
//  - Forwarding per operand, priority: mem_fwd (reg match & en) > wb_fwd > in_*_data. Combinational, same cycle.
//  - ALU: ADD, SUB, AND, ORR, NOT, TCP (two's complement), SHL/SHR (by 1, logical), ADI, ORI, LHI ({imm,8'h0}).
//    - LWD/SWD address = rs + sext(imm).
//    - All arithmetic mod 2^16; no overflow flag.
//  - Destination register:
//    - R-type → rd.
//    - ADI/ORI/LHI/LWD → rt.
//    - JAL/JRL → LINK_REG with value in_pc+1.
//    - SWD, branches, JMP, JPR, WWD, HLT → out_reg_write=0.
//  - Branches:
//    - BNE: rs!=rt. BEQ: rs==rt. BGZ: rs>0 (signed). BLZ: rs<0 (signed).
//    - Target = in_pc+1+sext(imm).
//    - JMP/JAL target = {in_pc[15:12],target}. JPR/JRL target = rs.
//    - Prediction is always not-taken, so taken branches and all jumps redirect.
//  - Latch update at posedge, reset inactive:
//    - mem_wait=1: every output register holds, including redirect_valid; ex_ready=0.
//    - squash (redirect_valid==1 this cycle) or in_valid=0: latch a bubble (out_valid=0, out_reg_write=0, out_inst=16'h0, opcode BNE, so MEM is idle). redirect_valid → 0.
//    - otherwise: latch the results; out_valid=1; redirect_valid=1 iff taken/jump, with redirect_pc.
//  - redirect_valid lasts exactly one unstalled cycle. The instruction presented with it is on the wrong path and never reaches MEM.
//  - WWD: wwd_value ← forwarded rs when latched.
//  - HLT: halted ← 1 when latched, and stays 1 until reset; later instructions become bubbles.
//  - Reset mid-stall: reset wins over mem_wait.
//  - Latency: 1 cycle ID/EX → EX/MEM. Throughput 1 instr/cycle when mem_wait=0.
// STRUCTURE
//  - Shared tsc_defs package/header: WORD_SIZE, opcode and func codes, field slices, NOP encoding.
//  - One sub-module, tsc_alu: combinational op/operand → result. Forwarding, branch logic and latch stay in stage_ex.
// TESTING
//  - Reset: hold reset_n=0 for 2 cycles with mem_wait=1 → all outputs zero, halted=0.
//  - Forward priority: ADD $1←$2+$3, with mem_fwd(reg 2, 16'h0005) and wb_fwd(reg 2, 16'h0009), rt_data=3 → out_addr=16'h0008.
//  - Stall hold: latch SWD (rs=16'h0010, imm=-1), then raise mem_wait for 4 cycles while in_inst changes → out_addr=16'h000F, out_write_data unchanged, ex_ready=0 throughout.
//  - Branch squash: BEQ at pc=16'h0020, imm=3, rs==rt → redirect_valid=1, redirect_pc=16'h0024. The next in_inst (ADI) latches as a bubble, out_valid=0.
//  - JAL at pc=16'h1005, target=12'h0AB → redirect_pc=16'h10AB, out_dest=2, out_addr=16'h1006, out_reg_write=1.
//  - HLT followed by ADD → halted=1 and stays 1. ADD latched as bubble. wwd_value unchanged.

Source files
------------

// File: rtl/tsc_defs_pkg.sv
// Shared TSC definitions: widths, opcode/func codes, ALU ops, EX/MEM payload.
package tsc_defs_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned REG_W     = 2;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned FUNC_W    = 6;

  localparam logic [REG_W-1:0] LINK_REG = 2'd2;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_BNE   = 4'd0;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'd1;
  localparam logic [OP_W-1:0] OP_BGZ   = 4'd2;
  localparam logic [OP_W-1:0] OP_BLZ   = 4'd3;
  localparam logic [OP_W-1:0] OP_ADI   = 4'd4;
  localparam logic [OP_W-1:0] OP_ORI   = 4'd5;
  localparam logic [OP_W-1:0] OP_LHI   = 4'd6;
  localparam logic [OP_W-1:0] OP_LWD   = 4'd7;
  localparam logic [OP_W-1:0] OP_SWD   = 4'd8;
  localparam logic [OP_W-1:0] OP_JMP   = 4'd9;
  localparam logic [OP_W-1:0] OP_JAL   = 4'd10;
  localparam logic [OP_W-1:0] OP_RTYPE = 4'd15;

  // R-type func codes
  localparam logic [FUNC_W-1:0] FN_ADD = 6'd0;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'd1;
  localparam logic [FUNC_W-1:0] FN_AND = 6'd2;
  localparam logic [FUNC_W-1:0] FN_ORR = 6'd3;
  localparam logic [FUNC_W-1:0] FN_NOT = 6'd4;
  localparam logic [FUNC_W-1:0] FN_TCP = 6'd5;
  localparam logic [FUNC_W-1:0] FN_SHL = 6'd6;
  localparam logic [FUNC_W-1:0] FN_SHR = 6'd7;
  localparam logic [FUNC_W-1:0] FN_JPR = 6'd25;
  localparam logic [FUNC_W-1:0] FN_JRL = 6'd26;
  localparam logic [FUNC_W-1:0] FN_WWD = 6'd28;
  localparam logic [FUNC_W-1:0] FN_HLT = 6'd29;

  // Opcode 0 (BNE) with no valid bit: MEM treats it as idle
  localparam logic [WORD_SIZE-1:0] NOP_INST = 16'h0000;

  // ALU ops 0..7 share encoding with the R-type func codes so decode can pass func through
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_NOT   = 4'd4,
    ALU_TCP   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_PASSB = 4'd8
  } alu_op_e;

  // EX/MEM pipeline latch payload
  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] inst;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] write_data;
    logic [REG_W-1:0]     dest;
    logic                 reg_write;
  } exmem_t;

  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/tsc_alu.sv
// Combinational TSC ALU: op and operands to result, arithmetic mod 2^16.
module tsc_alu
  import tsc_defs_pkg::*;
(
  input  logic [3:0]           i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_result
);

  // Operation select
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_NOT:   o_result = ~i_a;
      ALU_TCP:   o_result = ~i_a + WORD_SIZE'(1);
      ALU_SHL:   o_result = {i_a[WORD_SIZE-2:0], 1'b0};
      ALU_SHR:   o_result = {1'b0, i_a[WORD_SIZE-1:1]};
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/stage_ex.sv
// TSC execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM latch.
module stage_ex
  import tsc_defs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [15:0]          in_inst,
  input  logic [15:0]          in_pc,
  input  logic [15:0]          in_rs_data,
  input  logic [15:0]          in_rt_data,
  input  logic                 mem_wait,
  input  logic                 mem_fwd_en,
  input  logic [1:0]           mem_fwd_reg,
  input  logic [15:0]          mem_fwd_data,
  input  logic                 wb_fwd_en,
  input  logic [1:0]           wb_fwd_reg,
  input  logic [15:0]          wb_fwd_data,
  output logic                 ex_ready,
  output logic                 out_valid,
  output logic [15:0]          out_inst,
  output logic [15:0]          out_addr,
  output logic [15:0]          out_write_data,
  output logic [1:0]           out_dest,
  output logic                 out_reg_write,
  output logic                 redirect_valid,
  output logic [15:0]          redirect_pc,
  output logic [15:0]          wwd_value,
  output logic                 halted
);

  logic [OP_W-1:0]      w_opcode;
  logic [REG_W-1:0]     w_rs_idx, w_rt_idx, w_rd_idx;
  logic [FUNC_W-1:0]    w_func;
  logic [WORD_SIZE-1:0] w_simm, w_zimm, w_lhi_imm;
  logic [WORD_SIZE-1:0] w_rs_val, w_rt_val;
  logic [WORD_SIZE-1:0] w_br_target, w_jmp_target, w_link_val;
  logic [3:0]           w_alu_op;
  logic [WORD_SIZE-1:0] w_alu_b, w_alu_result;
  logic [REG_W-1:0]     w_dest;
  logic                 w_reg_write, w_link, w_taken, w_is_wwd, w_is_hlt, w_accept;
  logic [WORD_SIZE-1:0] w_target;

  exmem_t               r_exmem;
  logic                 r_redirect_valid;
  logic [WORD_SIZE-1:0] r_redirect_pc;
  logic [WORD_SIZE-1:0] r_wwd_value;
  logic                 r_halted;

  assign w_opcode     = in_inst[15:12];
  assign w_rs_idx     = in_inst[11:10];
  assign w_rt_idx     = in_inst[9:8];
  assign w_rd_idx     = in_inst[7:6];
  assign w_func       = in_inst[5:0];
  assign w_simm       = sext8(in_inst[7:0]);
  assign w_zimm       = {8'h00, in_inst[7:0]};
  assign w_lhi_imm    = {in_inst[7:0], 8'h00};
  assign w_link_val   = in_pc + WORD_SIZE'(1);
  assign w_br_target  = w_link_val + w_simm;
  assign w_jmp_target = {in_pc[15:12], in_inst[11:0]};

  // Operand forwarding: MEM result beats WB result beats register file
  always_comb begin
    w_rs_val = in_rs_data;
    if (mem_fwd_en && (mem_fwd_reg == w_rs_idx))     w_rs_val = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_reg == w_rs_idx))  w_rs_val = wb_fwd_data;
    w_rt_val = in_rt_data;
    if (mem_fwd_en && (mem_fwd_reg == w_rt_idx))     w_rt_val = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_reg == w_rt_idx))  w_rt_val = wb_fwd_data;
  end

  // Instruction decode: ALU control, destination, branch/jump resolution
  always_comb begin
    w_alu_op    = ALU_ADD;
    w_alu_b     = w_rt_val;
    w_dest      = '0;
    w_reg_write = 1'b0;
    w_link      = 1'b0;
    w_taken     = 1'b0;
    w_target    = w_br_target;
    w_is_wwd    = 1'b0;
    w_is_hlt    = 1'b0;
    case (w_opcode)
      OP_BNE: w_taken = (w_rs_val != w_rt_val);
      OP_BEQ: w_taken = (w_rs_val == w_rt_val);
      OP_BGZ: w_taken = !w_rs_val[WORD_SIZE-1] && (w_rs_val != '0);
      OP_BLZ: w_taken = w_rs_val[WORD_SIZE-1];
      OP_ADI: begin w_alu_b = w_simm;    w_dest = w_rt_idx; w_reg_write = 1'b1; end
      OP_ORI: begin w_alu_op = ALU_OR;   w_alu_b = w_zimm; w_dest = w_rt_idx; w_reg_write = 1'b1; end
      OP_LHI: begin w_alu_op = ALU_PASSB; w_alu_b = w_lhi_imm; w_dest = w_rt_idx; w_reg_write = 1'b1; end
      OP_LWD: begin w_alu_b = w_simm;    w_dest = w_rt_idx; w_reg_write = 1'b1; end
      OP_SWD: w_alu_b = w_simm;
      OP_JMP: begin w_taken = 1'b1; w_target = w_jmp_target; end
      OP_JAL: begin
        w_taken = 1'b1; w_target = w_jmp_target;
        w_link = 1'b1; w_dest = LINK_REG; w_reg_write = 1'b1;
      end
      OP_RTYPE: begin
        case (w_func)
          FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_NOT, FN_TCP, FN_SHL, FN_SHR: begin
            w_alu_op = w_func[3:0]; w_dest = w_rd_idx; w_reg_write = 1'b1;
          end
          FN_JPR: begin w_taken = 1'b1; w_target = w_rs_val; end
          FN_JRL: begin
            w_taken = 1'b1; w_target = w_rs_val;
            w_link = 1'b1; w_dest = LINK_REG; w_reg_write = 1'b1;
          end
          FN_WWD: w_is_wwd = 1'b1;
          FN_HLT: w_is_hlt = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  tsc_alu u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_rs_val),
    .i_b      (w_alu_b),
    .o_result (w_alu_result)
  );

  // Wrong-path instructions and anything after HLT become bubbles
  assign w_accept = in_valid && !r_redirect_valid && !r_halted;

  // EX/MEM latch, redirect pulse and architectural side registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exmem          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_wwd_value      <= '0;
      r_halted         <= 1'b0;
    end else if (!mem_wait) begin
      if (w_accept) begin
        r_exmem.valid      <= 1'b1;
        r_exmem.inst       <= in_inst;
        r_exmem.addr       <= w_link ? w_link_val : w_alu_result;
        r_exmem.write_data <= w_rt_val;
        r_exmem.dest       <= w_dest;
        r_exmem.reg_write  <= w_reg_write;
        r_redirect_valid   <= w_taken;
        if (w_taken)  r_redirect_pc <= w_target;
        if (w_is_wwd) r_wwd_value   <= w_rs_val;
        if (w_is_hlt) r_halted      <= 1'b1;
      end else begin
        r_exmem.valid     <= 1'b0;
        r_exmem.inst      <= NOP_INST;
        r_exmem.reg_write <= 1'b0;
        r_redirect_valid  <= 1'b0;
      end
    end
  end

  assign ex_ready       = !mem_wait;
  assign out_valid      = r_exmem.valid;
  assign out_inst       = r_exmem.inst;
  assign out_addr       = r_exmem.addr;
  assign out_write_data = r_exmem.write_data;
  assign out_dest       = r_exmem.dest;
  assign out_reg_write  = r_exmem.reg_write;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign wwd_value      = r_wwd_value;
  assign halted         = r_halted;

endmodule
